regfile_write_arbiter: RTL and testbench
========================================

// Module: regfile_write_arbiter
// PURPOSE
//  Shares the register file's single write port (ctrl_writeEnable / ctrl_writeRegister / data_writeReg)
//  between NUM_REQ independent write requesters (e.g. ALU writeback, load return, mult/div unit).
//  Round-robin arbitration with valid/ready handshake; one registered stage between grant and port.
//  Sits directly in front of the regfile write port; read path (mux trees) is untouched.
// PARAMETERS
//  NUM_REQ  4   number of requesters, legal 2..8
//  DATA_W   32  write data width
//  ADDR_W   5   register index width (32 registers)
// PORTS
//  clock               in   1                 single clock, all state updates on posedge
//  ctrl_reset          in   1                 synchronous, active-high reset
//  req_valid           in   NUM_REQ           requester i has a write pending
//  req_ready           out  NUM_REQ           one-hot/zero; transfer for i when valid[i] & ready[i]
//  req_addr            in   NUM_REQ*ADDR_W    flat; requester i at [i*ADDR_W +: ADDR_W]
//  req_data            in   NUM_REQ*DATA_W    flat; requester i at [i*DATA_W +: DATA_W]
//  wr_hold             in   1                 1 = accept nothing this cycle (flush/stall)
//  ctrl_writeEnable    out  1                 registered, to regfile
//  ctrl_writeRegister  out  ADDR_W            registered, to regfile
//  data_writeReg       out  DATA_W            registered, to regfile
//  grant_id            out  3                 registered, index of requester driving current write
// BEHAVIOUR
//  - Reset (ctrl_reset=1 at posedge): ctrl_writeEnable=0, ctrl_writeRegister=0, data_writeReg=0,
//    grant_id=0, rr_ptr=0. While ctrl_reset=1, req_ready=0 (combinationally forced).
//  - req_ready combinational: if wr_hold|ctrl_reset -> 0; else one-hot on first i with req_valid[i]
//    searching rr_ptr, rr_ptr+1, ... mod NUM_REQ. No valid -> 0.
//  - Requester must hold valid/addr/data stable until accepted; dropping valid unaccepted is legal.
//  - Accept at edge E: outputs at E = {1, addr_i, data_i, i}; regfile commits at edge E+1.
//    Latency accept->port = 1 cycle; throughput 1 write/cycle.
//  - No accept at edge: ctrl_writeEnable<=0; addr/data/grant_id hold previous values.
//  - rr_ptr <= (i+1) mod NUM_REQ after granting i; unchanged when nothing granted or wr_hold=1.
//  - Same-address writes from different requesters commit in grant order; no merging.
//  - Reset mid-operation: a capture coinciding with ctrl_reset is discarded; a write already
//    presented (writeEnable=1) is killed at the reset edge. No replay.
//  - req_valid bits >= NUM_REQ do not exist; grant_id upper bits 0 when NUM_REQ<8.
// CONFIGURATION
//  WRARB_R0_FILTER_EN defined: accepted writes with addr==0 are consumed (ready pulses, rr_ptr
//    advances) but ctrl_writeEnable stays 0 for that cycle; addr/data/grant_id still update.
//  Not defined: addr 0 writes are forwarded like any other (regfile ignores them).
// STRUCTURE
//  - Shared header regfile_defs.vh: REG_ADDR_W=5, REG_DATA_W=32, REG_COUNT=32, ARB_ID_W=3.
//  - One sub-module: rr_arbiter (NUM_REQ; in: req, ptr; out: one-hot grant, grant index).
//    Top holds rr_ptr, output registers, hold/reset gating, R0 filter.
// TESTING
//  1 ctrl_reset=1 two cycles, req_valid=4'b1111 -> req_ready=0, writeEnable=0, next grant = req 0.
//  2 only req 2: addr 5, data 32'hDEADBEEF -> ready=4'b0100 same cycle; next cycle writeEnable=1,
//    writeRegister=5, data_writeReg=32'hDEADBEEF, grant_id=2; cycle after writeEnable=0.
//  3 req_valid=4'b1111 held 8 cycles -> grant_id sequence 0,1,2,3,0,1,2,3, writeEnable=1 each.
//  4 wr_hold=1 3 cycles with valid=4'b0010 -> ready=0, writeEnable=0; release -> grant 1 next cycle.
//  5 rr_ptr=2 (after granting 1), valid=4'b1001 -> grant 3 then 0 (pointer wrap).
//  6 req 3 addr 0 data 7: with WRARB_R0_FILTER_EN -> ready[3]=1, writeEnable stays 0;
//    without -> writeEnable=1, writeRegister=0; rr_ptr=0 afterwards in both builds.
//  Plus reset mid-op: accept req 1 while ctrl_reset=1 -> no write ever presented.

Source files
------------

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared widths and helpers for the register-file write-port arbiter.
// Holds the register file geometry and the arbiter id width used by every file in this slice.
package regfile_write_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int REG_COUNT  = 32;
    localparam int ARB_ID_W   = 3;
    localparam int MAX_REQ    = 8;

    // Round-robin successor of a granted index, wrapping at the requester count.
    function automatic logic [ARB_ID_W-1:0] wrapInc(input logic [ARB_ID_W-1:0] idx,
                                                    input int                  numReq);
        logic [ARB_ID_W-1:0] result;
        if (int'(idx) >= numReq - 1) begin
            result = '0;
        end else begin
            result = idx + ARB_ID_W'(1);
        end
        return result;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr.sv
// Combinational round-robin picker: first asserted request at or after ptr_i, wrapping.
// Produces both a one-hot grant and the matching binary index.
module rr_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]  req_i,
    input  logic [ARB_ID_W-1:0] ptr_i,
    output logic [NUM_REQ-1:0]  grant_o,
    output logic [ARB_ID_W-1:0] grant_idx_o
);

    logic found;

    // Two passes: indices from the pointer upward, then the wrapped range below the pointer.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_i[i] && (i >= int'(ptr_i))) begin
                found       = 1'b1;
                grant_o[i]  = 1'b1;
                grant_idx_o = ARB_ID_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_i[i] && (i < int'(ptr_i))) begin
                found       = 1'b1;
                grant_o[i]  = 1'b1;
                grant_idx_o = ARB_ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port among NUM_REQ requesters with round-robin valid/ready.
// Optional macro WRARB_R0_FILTER_EN: accepted writes to register 0 are consumed without asserting writeEnable.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = REG_DATA_W,
    parameter int ADDR_W  = REG_ADDR_W
) (
    input  logic                      clock,
    input  logic                      ctrl_reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic                      wr_hold,
    output logic                      ctrl_writeEnable,
    output logic [ADDR_W-1:0]         ctrl_writeRegister,
    output logic [DATA_W-1:0]         data_writeReg,
    output logic [2:0]                grant_id
);

    logic [NUM_REQ-1:0]  arbGrant;
    logic [ARB_ID_W-1:0] arbIdx;
    logic                accept;
    logic                forwardWrite;
    logic [ADDR_W-1:0]   selAddr;
    logic [DATA_W-1:0]   selData;

    logic [ARB_ID_W-1:0] rrPtr_q,       rrPtr_d;
    logic                writeEnable_q, writeEnable_d;
    logic [ADDR_W-1:0]   writeReg_q,    writeReg_d;
    logic [DATA_W-1:0]   writeData_q,   writeData_d;
    logic [ARB_ID_W-1:0] grantId_q,     grantId_d;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_rr_arbiter (
        .req_i      (req_valid),
        .ptr_i      (rrPtr_q),
        .grant_o    (arbGrant),
        .grant_idx_o(arbIdx)
    );

    // Hold and reset both block the handshake so nothing is consumed that would then be dropped.
    assign req_ready = (wr_hold | ctrl_reset) ? '0 : arbGrant;
    assign accept    = |req_ready;

    always_comb begin
        selAddr = '0;
        selData = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arbIdx == ARB_ID_W'(i)) begin
                selAddr = req_addr[i*ADDR_W +: ADDR_W];
                selData = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef WRARB_R0_FILTER_EN
    logic isR0;
    assign isR0         = (selAddr == '0);
    assign forwardWrite = accept & ~isR0;
`else
    assign forwardWrite = accept;
`endif

    // Address, data and id only move on an accept so the port holds its last write otherwise.
    always_comb begin
        rrPtr_d       = rrPtr_q;
        writeEnable_d = forwardWrite;
        writeReg_d    = writeReg_q;
        writeData_d   = writeData_q;
        grantId_d     = grantId_q;
        if (accept) begin
            rrPtr_d     = wrapInc(arbIdx, NUM_REQ);
            writeReg_d  = selAddr;
            writeData_d = selData;
            grantId_d   = arbIdx;
        end
    end

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            rrPtr_q       <= '0;
            writeEnable_q <= 1'b0;
            writeReg_q    <= '0;
            writeData_q   <= '0;
            grantId_q     <= '0;
        end else begin
            rrPtr_q       <= rrPtr_d;
            writeEnable_q <= writeEnable_d;
            writeReg_q    <= writeReg_d;
            writeData_q   <= writeData_d;
            grantId_q     <= grantId_d;
        end
    end

    assign ctrl_writeEnable   = writeEnable_q;
    assign ctrl_writeRegister = writeReg_q;
    assign data_writeReg      = writeData_q;
    assign grant_id           = grantId_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: reset, single write, rotation, hold, wrap, r0, reset mid-op.
// Expected values are hand-computed; WRARB_R0_FILTER_EN selects the r0 expectation.
module tb_regfile_write_arbiter;

    localparam int NR = 4;
    localparam int AW = 5;
    localparam int DW = 32;

    logic              clock;
    logic              ctrl_reset;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_data;
    logic              wr_hold;
    logic              ctrl_writeEnable;
    logic [AW-1:0]     ctrl_writeRegister;
    logic [DW-1:0]     data_writeReg;
    logic [2:0]        grant_id;

    int total;
    int bad;

    regfile_write_arbiter #(
        .NUM_REQ(NR),
        .DATA_W (DW),
        .ADDR_W (AW)
    ) dut (
        .clock             (clock),
        .ctrl_reset        (ctrl_reset),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_addr          (req_addr),
        .req_data          (req_data),
        .wr_hold           (wr_hold),
        .ctrl_writeEnable  (ctrl_writeEnable),
        .ctrl_writeRegister(ctrl_writeRegister),
        .data_writeReg     (data_writeReg),
        .grant_id          (grant_id)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        req_addr[idx*AW +: AW] = addr;
        req_data[idx*DW +: DW] = data;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkPort(input string tag, input logic we, input logic [AW-1:0] reg_,
                             input logic [DW-1:0] data, input logic [2:0] gid);
        checkOutput({tag, ".we"},   32'(ctrl_writeEnable),   32'(we));
        checkOutput({tag, ".reg"},  32'(ctrl_writeRegister), 32'(reg_));
        checkOutput({tag, ".data"}, data_writeReg,           data);
        checkOutput({tag, ".gid"},  32'(grant_id),           32'(gid));
    endtask

    initial begin
        logic r0ExpectWe;
        total      = 0;
        bad        = 0;
        ctrl_reset = 1'b1;
        wr_hold    = 1'b0;
        req_valid  = 4'b1111;
        req_addr   = '0;
        req_data   = '0;
        for (int i = 0; i < NR; i++) applyStimulus(i, AW'(10 + i), 32'hA0 + 32'(i));

        // Reset held two cycles with everyone requesting.
        #1;
        checkOutput("rst.ready", 32'(req_ready), 32'h0);
        tick();
        checkOutput("rst.we1", 32'(ctrl_writeEnable), 32'h0);
        tick();
        checkPort("rst", 1'b0, 5'd0, 32'h0, 3'd0);
        ctrl_reset = 1'b0;
        #1;
        checkOutput("rst.next", 32'(req_ready), 32'b0001);
        req_valid = 4'b0000;
        #1;
        checkOutput("idle.ready", 32'(req_ready), 32'h0);

        // Single requester 2.
        applyStimulus(2, 5'd5, 32'hDEADBEEF);
        req_valid = 4'b0100;
        #1;
        checkOutput("single.ready", 32'(req_ready), 32'b0100);
        tick();
        checkPort("single", 1'b1, 5'd5, 32'hDEADBEEF, 3'd2);
        req_valid = 4'b0000;
        tick();
        checkPort("single.after", 1'b0, 5'd5, 32'hDEADBEEF, 3'd2);

        // Reset back to pointer 0, then full rotation.
        ctrl_reset = 1'b1;
        tick();
        ctrl_reset = 1'b0;
        applyStimulus(2, 5'd12, 32'hA2);
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            checkOutput($sformatf("rot%0d.ready", k), 32'(req_ready), 32'(1) << (k % 4));
            tick();
            checkPort($sformatf("rot%0d", k), 1'b1, AW'(10 + k % 4), 32'hA0 + 32'(k % 4), 3'(k % 4));
        end
        req_valid = 4'b0000;

        // Hold blocks acceptance, release grants requester 1.
        wr_hold   = 1'b1;
        req_valid = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            #1;
            checkOutput($sformatf("hold%0d.ready", k), 32'(req_ready), 32'h0);
            tick();
            checkOutput($sformatf("hold%0d.we", k), 32'(ctrl_writeEnable), 32'h0);
        end
        wr_hold = 1'b0;
        #1;
        checkOutput("release.ready", 32'(req_ready), 32'b0010);
        tick();
        checkPort("release", 1'b1, 5'd11, 32'hA1, 3'd1);
        req_valid = 4'b0000;

        // Pointer at 2: requester 3 wins before 0.
        req_valid = 4'b1001;
        #1;
        checkOutput("wrap.ready3", 32'(req_ready), 32'b1000);
        tick();
        checkPort("wrap3", 1'b1, 5'd13, 32'hA3, 3'd3);
        req_valid = 4'b0001;
        #1;
        checkOutput("wrap.ready0", 32'(req_ready), 32'b0001);
        tick();
        checkPort("wrap0", 1'b1, 5'd10, 32'hA0, 3'd0);
        req_valid = 4'b0000;

        // Write to register 0 from requester 3.
`ifdef WRARB_R0_FILTER_EN
        r0ExpectWe = 1'b0;
`else
        r0ExpectWe = 1'b1;
`endif
        applyStimulus(3, 5'd0, 32'h7);
        req_valid = 4'b1000;
        #1;
        checkOutput("r0.ready", 32'(req_ready), 32'b1000);
        tick();
        checkPort("r0", r0ExpectWe, 5'd0, 32'h7, 3'd3);
        req_valid = 4'b1111;
        #1;
        checkOutput("r0.ptr", 32'(req_ready), 32'b0001);
        req_valid = 4'b0000;
        tick();
        checkOutput("r0.idle.we", 32'(ctrl_writeEnable), 32'h0);

        // Reset mid-operation kills the presented write and the coinciding capture.
        req_valid = 4'b0010;
        tick();
        checkPort("midop.pre", 1'b1, 5'd11, 32'hA1, 3'd1);
        ctrl_reset = 1'b1;
        #1;
        checkOutput("midop.ready", 32'(req_ready), 32'h0);
        tick();
        checkPort("midop.rst", 1'b0, 5'd0, 32'h0, 3'd0);
        ctrl_reset = 1'b0;
        req_valid  = 4'b0000;
        tick();
        checkOutput("midop.after.we", 32'(ctrl_writeEnable), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
